// File: rtl/mult_arb_pkg.sv
// rtl/mult_arb_pkg.sv - shared widths, latency and pipeline tag type for mult_arbiter
package mult_arb_pkg;

    localparam int MULT_W   = 18;
    localparam int PROD_W   = 36;
    localparam int MULT_LAT = 3;
    // Tag width covers the largest supported requester count (8).
    localparam int STG_IDW  = 3;

    typedef struct packed {
        logic               vld;
        logic [STG_IDW-1:0] id;
    } stage_t;

endpackage

// File: rtl/mult18x18_3c.sv
// rtl/mult18x18_3c.sv - signed 18x18 multiplier, input/pipeline/output registers, common CE
module mult18x18_3c (
    input  logic               CLK,
    input  logic               CE0,
    input  logic               RST0,
    input  logic signed [17:0] A,
    input  logic signed [17:0] B,
    output logic signed [35:0] O
);

    logic signed [17:0] a_q, b_q;
    logic signed [35:0] p_q, o_q;

    always_ff @(posedge CLK) begin
        if (RST0) begin
            a_q <= '0;
            b_q <= '0;
            p_q <= '0;
            o_q <= '0;
        end else if (CE0) begin
            a_q <= A;
            b_q <= B;
            p_q <= a_q * b_q;
            o_q <= p_q;
        end
    end

    assign O = o_q;

endmodule

// File: rtl/rr_arbiter.sv
// rtl/rr_arbiter.sv - combinational round-robin arbiter, priority starts after last grant
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDW-1:0]  last_i,
    output logic [NREQ-1:0] grant_o,
    output logic [IDW-1:0]  grant_id_o,
    output logic            any_o
);

    always_comb begin
        int idx;
        idx        = 0;
        grant_o    = '0;
        grant_id_o = '0;
        any_o      = 1'b0;
        // Walk from last+1 around the ring; first asserted request wins.
        for (int i = 1; i <= NREQ; i++) begin
            idx = (int'(last_i) + i) % NREQ;
            if (!any_o && req_i[idx]) begin
                any_o        = 1'b1;
                grant_o[idx] = 1'b1;
                grant_id_o   = IDW'(idx);
            end
        end
    end

endmodule

// File: rtl/mult_arbiter.sv
// rtl/mult_arbiter.sv - shares one 3-stage 18x18 multiplier among NREQ requesters with tagged return
module mult_arbiter
    import mult_arb_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = $clog2(NREQ)
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic [NREQ-1:0]          req_valid,
    output logic [NREQ-1:0]          req_ready,
    input  logic [NREQ*MULT_W-1:0]   req_a,
    input  logic [NREQ*MULT_W-1:0]   req_b,
    output logic [NREQ-1:0]          resp_valid,
    input  logic [NREQ-1:0]          resp_ready,
    output logic [PROD_W-1:0]        resp_o,
    output logic                     busy
);

    logic [NREQ-1:0]           grant;
    logic [IDW-1:0]            grant_id;
    logic                      arb_any;
    logic [IDW-1:0]            last_q, last_d;
    stage_t [MULT_LAT-1:0]     stg_q, stg_d;
    logic                      stall, en, accept;
    logic signed [MULT_W-1:0]  mul_a, mul_b;
    logic signed [PROD_W-1:0]  mul_o;

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req_i      (req_valid),
        .last_i     (last_q),
        .grant_o    (grant),
        .grant_id_o (grant_id),
        .any_o      (arb_any)
    );

    // The output stage's owner decides whether the whole pipe may move.
    always_comb begin
        resp_valid = stg_q[MULT_LAT-1].vld ? (NREQ'(1) << stg_q[MULT_LAT-1].id) : '0;
        stall      = |(resp_valid & ~resp_ready);
        en         = rst | ~stall;
        req_ready  = grant & {NREQ{en & ~rst}};
        accept     = arb_any & en & ~rst;
        busy       = 1'b0;
        for (int k = 0; k < MULT_LAT; k++) begin
            busy = busy | stg_q[k].vld;
        end
    end

    // Operands fall to zero when nothing is granted so idle cycles do not toggle the DSP.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (grant[i]) begin
                mul_a = req_a[i*MULT_W +: MULT_W];
                mul_b = req_b[i*MULT_W +: MULT_W];
            end
        end
    end

    always_comb begin
        stg_d  = stg_q;
        last_d = last_q;
        if (en) begin
            stg_d[0].vld = accept;
            stg_d[0].id  = STG_IDW'(grant_id);
            for (int k = 1; k < MULT_LAT; k++) begin
                stg_d[k] = stg_q[k-1];
            end
        end
        if (accept) begin
            last_d = grant_id;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            stg_q  <= '0;
            last_q <= IDW'(NREQ - 1);
        end else begin
            stg_q  <= stg_d;
            last_q <= last_d;
        end
    end

    mult18x18_3c u_mult (
        .CLK  (clk),
        .CE0  (en),
        .RST0 (rst),
        .A    (mul_a),
        .B    (mul_b),
        .O    (mul_o)
    );

    assign resp_o = mul_o;

endmodule

// File: tb/tb_mult_arbiter.sv
// tb/tb_mult_arbiter.sv - directed self-checking bench for mult_arbiter
module tb_mult_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [3:0]  req_valid;
    logic [3:0]  req_ready;
    logic [71:0] req_a;
    logic [71:0] req_b;
    logic [3:0]  resp_valid;
    logic [3:0]  resp_ready;
    logic [35:0] resp_o;
    logic        busy;

    int total = 0;
    int bad   = 0;

    mult_arbiter #(.NREQ(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_o     (resp_o),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int i, input logic [17:0] a, input logic [17:0] b);
        req_a[18*i +: 18] = a;
        req_b[18*i +: 18] = b;
    endtask

    task automatic do_reset;
        rst        = 1'b1;
        req_valid  = 4'b0000;
        resp_ready = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset;
        rst        = 1'b1;
        req_valid  = 4'b1111;
        resp_ready = 4'b1111;
        req_a      = '0;
        req_b      = '0;
        tick();
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL reset_req_ready got=%b exp=0000", req_ready);
        end
        req_valid = 4'b0000;
        tick();
        rst = 1'b0;
        #1;
        total++;
        if (resp_valid !== 4'b0000 || busy !== 1'b0 || resp_o !== 36'h0) begin
            bad++;
            $display("FAIL reset_state got rv=%b busy=%b o=%h exp rv=0000 busy=0 o=0", resp_valid, busy, resp_o);
        end
    endtask

    task automatic test_single;
        logic [3:0] exp_rv;
        logic       exp_busy;
        do_reset();
        for (int c = 0; c < 5; c++) begin
            req_valid = (c == 0) ? 4'b0001 : 4'b0000;
            if (c == 0) set_op(0, 18'd3, -18'sd5);
            #1;
            exp_rv   = (c == 3) ? 4'b0001 : 4'b0000;
            exp_busy = (c >= 1 && c <= 3);
            total++;
            if (req_ready !== ((c == 0) ? 4'b0001 : 4'b0000)) begin
                bad++;
                $display("FAIL single_ready c=%0d got=%b", c, req_ready);
            end
            total++;
            if (resp_valid !== exp_rv || busy !== exp_busy) begin
                bad++;
                $display("FAIL single_resp c=%0d got rv=%b busy=%b exp rv=%b busy=%b", c, resp_valid, busy, exp_rv, exp_busy);
            end
            if (c == 3) begin
                total++;
                if (resp_o !== 36'hF_FFFF_FFF1) begin
                    bad++;
                    $display("FAIL single_product got=%h exp=FFFFFFFF1", resp_o);
                end
            end
            tick();
        end
    endtask

    task automatic test_round_robin;
        logic [35:0] prod [0:3];
        int          o;
        prod[0] = 36'd10;
        prod[1] = 36'd40;
        prod[2] = 36'd90;
        prod[3] = 36'd160;
        do_reset();
        for (int i = 0; i < 4; i++) set_op(i, 18'(i + 1), 18'(10 * (i + 1)));
        for (int c = 0; c < 9; c++) begin
            req_valid = (c < 5) ? 4'b1111 : 4'b0000;
            #1;
            total++;
            if (req_ready !== ((c < 5) ? (4'b0001 << (c % 4)) : 4'b0000)) begin
                bad++;
                $display("FAIL rr_grant c=%0d got=%b", c, req_ready);
            end
            if (c >= 3 && c <= 7) begin
                o = (c - 3) % 4;
                total++;
                if (resp_valid !== (4'b0001 << o) || resp_o !== prod[o]) begin
                    bad++;
                    $display("FAIL rr_resp c=%0d got rv=%b o=%0d exp rv=%b o=%0d", c, resp_valid, resp_o, 4'b0001 << o, prod[o]);
                end
            end else begin
                total++;
                if (resp_valid !== 4'b0000) begin
                    bad++;
                    $display("FAIL rr_idle c=%0d got rv=%b exp 0000", c, resp_valid);
                end
            end
            tick();
        end
    endtask

    task automatic test_backpressure;
        logic [3:0]  t_vld [0:9] = '{4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b1000,
                                     4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  t_rdy [0:9] = '{4'b1111, 4'b1111, 4'b1111, 4'b1101, 4'b1101,
                                     4'b1111, 4'b1111, 4'b1111, 4'b1111, 4'b1111};
        logic [3:0]  t_rr  [0:9] = '{4'b0010, 4'b0010, 4'b0010, 4'b0000, 4'b0000,
                                     4'b1000, 4'b0000, 4'b0000, 4'b0000, 4'b0000};
        logic [3:0]  t_rv  [0:9] = '{4'b0000, 4'b0000, 4'b0000, 4'b0010, 4'b0010,
                                     4'b0010, 4'b0010, 4'b0010, 4'b1000, 4'b0000};
        logic [35:0] t_o   [0:9] = '{36'd0, 36'd0, 36'd0, 36'd1, 36'd1,
                                     36'd1, 36'd4, 36'd9, 36'd25, 36'd0};
        do_reset();
        set_op(3, 18'd5, 18'd5);
        for (int c = 0; c < 10; c++) begin
            if (c < 3) set_op(1, 18'(c + 1), 18'(c + 1));
            req_valid  = t_vld[c];
            resp_ready = t_rdy[c];
            #1;
            total++;
            if (req_ready !== t_rr[c]) begin
                bad++;
                $display("FAIL bp_ready c=%0d got=%b exp=%b", c, req_ready, t_rr[c]);
            end
            total++;
            if (resp_valid !== t_rv[c]) begin
                bad++;
                $display("FAIL bp_rvalid c=%0d got=%b exp=%b", c, resp_valid, t_rv[c]);
            end
            if (t_rv[c] != 4'b0000) begin
                total++;
                if (resp_o !== t_o[c]) begin
                    bad++;
                    $display("FAIL bp_product c=%0d got=%0d exp=%0d", c, resp_o, t_o[c]);
                end
            end
            if (c == 9) begin
                total++;
                if (busy !== 1'b0) begin
                    bad++;
                    $display("FAIL bp_drain got busy=%b exp=0", busy);
                end
            end
            tick();
        end
    endtask

    task automatic test_extremes;
        logic [35:0] exp_o [0:2] = '{36'h4_0000_0000, 36'hC_0002_0000, 36'h3_FFFC_0001};
        do_reset();
        for (int c = 0; c < 6; c++) begin
            req_valid = (c < 3) ? 4'b0001 : 4'b0000;
            case (c)
                0: set_op(0, 18'h20000, 18'h20000);
                1: set_op(0, 18'h1FFFF, 18'h20000);
                2: set_op(0, 18'h1FFFF, 18'h1FFFF);
                default: set_op(0, 18'h0, 18'h0);
            endcase
            #1;
            if (c >= 3) begin
                total++;
                if (resp_valid !== 4'b0001 || resp_o !== exp_o[c-3]) begin
                    bad++;
                    $display("FAIL extreme_%0d got rv=%b o=%h exp rv=0001 o=%h", c - 3, resp_valid, resp_o, exp_o[c-3]);
                end
            end
            tick();
        end
    endtask

    task automatic test_fairness;
        logic [3:0] exp_rr;
        do_reset();
        set_op(0, 18'd1, 18'd1);
        set_op(2, 18'd7, -18'sd3);
        for (int c = 0; c < 10; c++) begin
            req_valid = (c == 5) ? 4'b0101 : 4'b0001;
            #1;
            exp_rr = (c == 5) ? 4'b0100 : 4'b0001;
            total++;
            if (req_ready !== exp_rr) begin
                bad++;
                $display("FAIL fair_grant c=%0d got=%b exp=%b", c, req_ready, exp_rr);
            end
            if (c == 8) begin
                total++;
                if (resp_valid !== 4'b0100 || resp_o !== 36'hF_FFFF_FFEB) begin
                    bad++;
                    $display("FAIL fair_resp got rv=%b o=%h exp rv=0100 o=FFFFFFFEB", resp_valid, resp_o);
                end
            end
            tick();
        end
        req_valid = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_midflight;
        do_reset();
        set_op(0, 18'd6, 18'd7);
        set_op(1, 18'd2, 18'd2);
        set_op(2, 18'd3, 18'd3);
        for (int c = 0; c < 4; c++) begin
            req_valid = 4'b0111;
            tick();
        end
        rst       = 1'b1;
        req_valid = 4'b0111;
        #1;
        total++;
        if (req_ready !== 4'b0000) begin
            bad++;
            $display("FAIL mid_rst_ready got=%b exp=0000", req_ready);
        end
        tick();
        rst = 1'b0;
        for (int c = 0; c < 4; c++) begin
            req_valid = (c == 0) ? 4'b0011 : 4'b0000;
            #1;
            if (c == 0) begin
                total++;
                if (resp_valid !== 4'b0000 || busy !== 1'b0 || resp_o !== 36'h0) begin
                    bad++;
                    $display("FAIL mid_after_rst got rv=%b busy=%b o=%h exp 0000/0/0", resp_valid, busy, resp_o);
                end
                total++;
                if (req_ready !== 4'b0001) begin
                    bad++;
                    $display("FAIL mid_priority got=%b exp=0001", req_ready);
                end
            end else if (c < 3) begin
                total++;
                if (resp_valid !== 4'b0000) begin
                    bad++;
                    $display("FAIL mid_stale c=%0d got rv=%b exp 0000", c, resp_valid);
                end
            end else begin
                total++;
                if (resp_valid !== 4'b0001 || resp_o !== 36'd42) begin
                    bad++;
                    $display("FAIL mid_resp got rv=%b o=%0d exp rv=0001 o=42", resp_valid, resp_o);
                end
            end
            tick();
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_round_robin();
        test_backpressure();
        test_extremes();
        test_fairness();
        test_reset_midflight();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
